// File: rtl/waveform_pkg.sv
// Shared constants and types for the waveform generator: select codes,
// triangle direction and reset/midscale values.
package waveform_pkg;

    localparam logic [2:0] WAVE_SAW   = 3'd0;
    localparam logic [2:0] WAVE_RSAW  = 3'd1;
    localparam logic [2:0] WAVE_TRI   = 3'd2;
    localparam logic [2:0] WAVE_SQR   = 3'd3;
    localparam logic [2:0] WAVE_PWM   = 3'd4;
    localparam logic [2:0] WAVE_STAIR = 3'd5;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } tri_dir_t;

    localparam logic [7:0] DUTY_RST   = 8'h80;
    localparam logic [7:0] SAMPLE_MID = 8'h80;

endpackage

// File: rtl/wave_tri_fsm.sv
// Triangle up/down counter: climbs 00..FF, then descends FF..00, so each
// extreme appears exactly once per 2*(2^W-1) advances.
module wave_tri_fsm
    import waveform_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] tri_val
);

    localparam logic [W-1:0] TOP_TURN = {{(W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0] BOT_TURN = W'(1);

    tri_dir_t     dir_q, dir_d;
    logic [W-1:0] val_q, val_d;

    // NOTE: asynchronous reset sits in the sensitivity list; state uses <= so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q <= '0;
            dir_q <= UP;
        end else begin
            val_q <= val_d;
            dir_q <= dir_d;
        end
    end

    // NOTE: defaults first, so every path assigns every output and no latch forms.
    always_comb begin
        val_d = val_q;
        dir_d = dir_q;
        if (adv) begin
            case (dir_q)
                UP: begin
                    val_d = val_q + 1'b1;
                    if (val_q == TOP_TURN) dir_d = DOWN;
                end
                DOWN: begin
                    val_d = val_q - 1'b1;
                    if (val_q == BOT_TURN) dir_d = UP;
                end
                default: dir_d = UP;
            endcase
        end
    end

    assign tri_val = val_q;

endmodule

// File: rtl/waveform_generator.sv
// Tick-driven waveform generator: stage 1 advances phase, triangle and duty
// latch; stage 2 registers the selected sample with a one-cycle valid strobe.
module waveform_generator
    import waveform_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         en,
    input  logic [2:0]   wave_sel,
    input  logic [W-1:0] duty,
    output logic [W-1:0] sample,
    output logic         sample_vld
);

    logic         adv;
    logic [W-1:0] phase_q, phase_d;
    logic [W-1:0] duty_q, duty_d;
    logic         tick_dly_q, tick_dly_d;
    logic [W-1:0] sample_q, sample_d;
    logic         sample_vld_q, sample_vld_d;
    logic [W-1:0] tri_val;
    logic [W-1:0] wave_val;

    assign adv = tick & en;

    wave_tri_fsm #(.W(W)) u_tri (
        .clk     (clk),
        .reset   (reset),
        .adv     (adv),
        .tri_val (tri_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= '0;
            duty_q       <= W'(DUTY_RST);
            tick_dly_q   <= 1'b0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            duty_q       <= duty_d;
            tick_dly_q   <= tick_dly_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
        end
    end

    // Duty is only picked up on the wrap edge so a PWM period is never split.
    always_comb begin
        phase_d    = phase_q;
        duty_d     = duty_q;
        tick_dly_d = adv;
        if (adv) begin
            phase_d = phase_q + 1'b1;
            if (phase_q == '1) duty_d = duty;
        end
    end

    always_comb begin
        wave_val = W'(SAMPLE_MID);
        case (wave_sel)
            WAVE_SAW:   wave_val = phase_q;
            WAVE_RSAW:  wave_val = ~phase_q;
            WAVE_TRI:   wave_val = tri_val;
            WAVE_SQR:   wave_val = phase_q[W-1] ? '0 : '1;
            WAVE_PWM:   wave_val = (phase_q < duty_q) ? '1 : '0;
            WAVE_STAIR: wave_val = {phase_q[W-1:W-3], {(W-3){1'b0}}};
            default:    wave_val = W'(SAMPLE_MID);
        endcase
    end

    // Stage 2 completes any sample already launched, even if en has dropped.
    always_comb begin
        sample_d     = sample_q;
        sample_vld_d = tick_dly_q;
        if (tick_dly_q) sample_d = wave_val;
    end

    assign sample     = sample_q;
    assign sample_vld = sample_vld_q;

endmodule

// File: tb/tb_waveform_generator.sv
// Directed self-checking bench for waveform_generator; expected samples are
// derived from tick counts with closed-form formulas.
module tb_waveform_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       en;
    logic [2:0] wave_sel;
    logic [7:0] duty;
    logic [7:0] sample;
    logic       sample_vld;

    int checks = 0;
    int errors = 0;

    waveform_generator #(.W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .en         (en),
        .wave_sel   (wave_sel),
        .duty       (duty),
        .sample     (sample),
        .sample_vld (sample_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected sample once t ticks have been accepted since reset.
    function automatic logic [7:0] exp_wave(input int sel, input int t);
        int p;
        int m;
        p = t % 256;
        m = t % 510;
        case (sel)
            0:       return 8'(p);
            2:       return (m <= 255) ? 8'(m) : 8'(510 - m);
            3:       return (p < 128) ? 8'hFF : 8'h00;
            5:       return 8'(p) & 8'hE0;
            default: return 8'h80;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick  = 1'b0;
        @(negedge clk);
        check("rst_sample", sample, 8'h00);
        check("rst_vld", sample_vld, 1'b0);
        reset = 1'b0;
    endtask

    // Isolated tick: no strobe one cycle later, strobe with sample two cycles later.
    task automatic tick_and_check(input string tag, input logic [7:0] exp);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check({tag, "_early"}, sample_vld, 1'b0);
        @(negedge clk);
        check({tag, "_vld"}, sample_vld, 1'b1);
        check(tag, sample, exp);
    endtask

    // Hold tick for n edges; after edge k the sample reflects k-1 ticks.
    task automatic burst(input string tag, input int n);
        @(negedge clk);
        tick = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_first_vld"}, sample_vld, 1'b0);
            end else begin
                check({tag, "_vld"}, sample_vld, 1'b1);
                check(tag, sample, exp_wave(int'(wave_sel), k - 1));
            end
        end
        tick = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        en       = 1'b1;
        wave_sel = 3'd0;
        duty     = 8'hC0;

        // Reset values, then three isolated saw samples
        do_reset();
        tick_and_check("saw1", 8'h01);
        tick_and_check("saw2", 8'h02);
        tick_and_check("saw3", 8'h03);
        @(negedge clk);
        check("saw_vld_drop", sample_vld, 1'b0);

        // Triangle over more than one 510-tick period
        do_reset();
        wave_sel = 3'd2;
        burst("tri", 521);

        // PWM: duty 80 first period despite mid-period change, then 40, 00, FF
        do_reset();
        wave_sel = 3'd4;
        duty     = 8'hC0;
        @(negedge clk);
        tick = 1'b1;
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (k == 16)  duty = 8'h40;
            if (k == 300) duty = 8'h00;
            if (k == 600) duty = 8'hFF;
            if (k >= 2) begin
                int t;
                int p;
                int de;
                t  = k - 1;
                p  = t % 256;
                de = (t < 256) ? 'h80 : (t < 512) ? 'h40 : (t < 768) ? 'h00 : 'hFF;
                check("pwm", sample, (p < de) ? 8'hFF : 8'h00);
            end
        end
        tick = 1'b0;

        // en=0 freezes phase; a launched sample still completes
        do_reset();
        wave_sel = 3'd3;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        check("en_first_vld", sample_vld, 1'b0);
        @(negedge clk);
        check("en_sqr1", sample, 8'hFF);
        @(negedge clk);
        check("en_sqr2", sample, 8'hFF);
        en = 1'b0;
        @(negedge clk);
        check("en_pending_vld", sample_vld, 1'b1);
        check("en_pending", sample, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("en_off_vld", sample_vld, 1'b0);
        end
        en       = 1'b1;
        tick     = 1'b0;
        wave_sel = 3'd0;
        tick_and_check("en_resume", 8'h04);

        // Staircase and square with continuous ticks across the phase wrap
        do_reset();
        wave_sel = 3'd5;
        burst("stair", 300);
        do_reset();
        wave_sel = 3'd3;
        burst("sqr", 260);

        // Asynchronous reset mid-stream at phase 9A
        do_reset();
        wave_sel = 3'd0;
        burst("pre_rst", 'h9A);
        #2 reset = 1'b1;
        #1;
        check("async_rst_sample", sample, 8'h00);
        check("async_rst_vld", sample_vld, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick_and_check("post_rst_saw", 8'h01);
        wave_sel = 3'd6;
        tick_and_check("sel6_mid", 8'h80);
        wave_sel = 3'd1;
        tick_and_check("rsaw", 8'hFC);
        wave_sel = 3'd2;
        tick_and_check("post_rst_tri", 8'h04);
        wave_sel = 3'd7;
        tick_and_check("sel7_mid", 8'h80);
        wave_sel = 3'd5;
        tick_and_check("stair6", 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
